// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder: one shared 4-bit slice, LSB nibble first, carry rippled through a flop.
// Optional macro SUB_EN_EN adds a 'sub' port selecting A-B (two's complement via ~B and carry-in 1).
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SUB_EN_EN
  ,
  input  logic             sub
`endif
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d, cout_q, cout_d;

  logic [3:0] a_nib, b_nib, slice_s;
  logic       slice_co;

  // Operand nibble select for the current step.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IDXW'(n)) begin
        a_nib = a_q[4*n +: 4];
        b_nib = b_q[4*n +: 4];
      end
    end
  end

  assign {slice_co, slice_s} = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = ina;
          b_d     = inb;
          carry_d = cin;
`ifdef SUB_EN_EN
          // Subtract as A + ~B + 1; cin is not used in this mode.
          if (sub) begin
            b_d     = ~inb;
            carry_d = 1'b1;
          end
`endif
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int n = 0; n < NIB; n++) begin
          if (idx_q == IDXW'(n)) sum_d[4*n +: 4] = slice_s;
        end
        carry_d = slice_co;
        if (idx_q == IDXW'(NIB - 1)) begin
          cout_d  = slice_co;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl: WIDTH=16 and WIDTH=4 instances, directed vectors.
module tb_nibble_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 16-bit instance
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [15:0] ina, inb, sum;
`ifdef SUB_EN_EN
  logic        sub;
`endif
  logic [16:0] q16[$];

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ina(ina), .inb(inb), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef SUB_EN_EN
    , .sub(sub)
`endif
  );

  // 4-bit instance
  logic       in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, busy4;
  logic [3:0] ina4, inb4, sum4;
  logic [4:0] q4[$];

  nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .ina(ina4), .inb(inb4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
`ifdef SUB_EN_EN
    , .sub(1'b0)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare on every result handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q16.size() == 0) chk("w16 unexpected out_valid", 32'(out_valid), 32'd0);
      else begin
        logic [16:0] e;
        e = q16.pop_front();
        chk("w16 result {cout,sum}", {15'd0, cout, sum}, {15'd0, e});
      end
    end
    if (!rst && out_valid4 && out_ready4) begin
      if (q4.size() == 0) chk("w4 unexpected out_valid", 32'(out_valid4), 32'd0);
      else begin
        logic [4:0] e4;
        e4 = q4.pop_front();
        chk("w4 result {cout,sum}", {27'd0, cout4, sum4}, {27'd0, e4});
      end
    end
  end

  // Issue one op on the 16-bit instance; checks acceptance and latency, returns after out_valid rises.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                      input logic [16:0] exp);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    chk("w16 in_ready before accept", 32'(in_ready), 32'd1);
    ina = a; inb = b; cin = c; in_valid = 1'b1;
`ifdef SUB_EN_EN
    sub = s;
`else
    if (s) $display("note: sub op skipped without SUB_EN_EN");
`endif
    q16.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("w16 busy after accept", 32'({busy, in_ready}), 32'b10);
    for (k = 1; k <= 20; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    chk("w16 latency", 32'(k), 32'd5);
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; out_ready = 1; cin = 0; ina = 0; inb = 0;
    in_valid4 = 0; out_ready4 = 1; cin4 = 0; ina4 = 0; inb4 = 0;
`ifdef SUB_EN_EN
    sub = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready/out_valid/busy", 32'({in_ready, out_valid, busy}), 32'b100);
    chk("reset sum/cout", 32'({cout, sum}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // k counts the accept edge too, so latency 4 shows as 5.
    op16(16'h1234, 16'h0FFF, 1'b0, 1'b0, {1'b0, 16'h2233});
    @(posedge clk); #1;
    chk("in_ready after result handshake", 32'({in_ready, out_valid}), 32'b10);

    op16(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b1, 16'h0000});
    op16(16'hABCD, 16'h1111, 1'b0, 1'b0, {1'b0, 16'hBCDE});
    op16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b1, 16'hFFFF});

    // Back-pressure: hold result for 3 cycles.
    @(posedge clk); #1;
    out_ready = 1'b0;
    op16(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 16'h0000});
    for (int i = 0; i < 3; i++) begin
      chk("stall flags", 32'({out_valid, in_ready}), 32'b10);
      chk("stall {cout,sum}", 32'({cout, sum}), 32'h10000);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("after stall release", 32'({in_ready, out_valid}), 32'b10);

    // Mid-RUN reset discards the operation.
    ina = 16'h00FF; inb = 16'h0001; cin = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; ina = 16'hAAAA; inb = 16'h5555;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async reset flags", 32'({in_ready, out_valid, busy}), 32'b100);
    chk("async reset sum/cout", 32'({cout, sum}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("no out_valid after reset", 32'(out_valid), 32'd0);
    op16(16'h0003, 16'h0004, 1'b1, 1'b0, {1'b0, 16'h0008});

`ifdef SUB_EN_EN
    op16(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 16'hFFFE});
    op16(16'h0007, 16'h0005, 1'b0, 1'b1, {1'b1, 16'h0002});
    op16(16'h0007, 16'h0005, 1'b0, 1'b0, {1'b0, 16'h000C});
`endif

    // WIDTH=4: latency 1.
    for (int t = 0; t < 2; t++) begin
      ina4 = (t == 0) ? 4'h9 : 4'hF;
      inb4 = (t == 0) ? 4'h8 : 4'h0;
      cin4 = (t == 0);
      q4.push_back((t == 0) ? 5'h12 : 5'h0F);
      in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      chk("w4 not valid at accept", 32'(out_valid4), 32'd0);
      @(posedge clk); #1;
      chk("w4 out_valid 1 cycle later", 32'(out_valid4), 32'd1);
      @(posedge clk); #1;
      chk("w4 back to idle", 32'(in_ready4), 32'd1);
    end

    for (int k = 0; k < 20 && (q16.size() != 0 || q4.size() != 0); k++) @(posedge clk);
    chk("scoreboard drained", 32'(q16.size() + q4.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that time-shares one 4-bit adder slice to add WIDTH-bit operands one nibble per cycle, LSB nibble first, rippling the carry through a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Area-cheap alternative to a full WIDTH-bit adder for the arithmetic datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble steps (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  controller can accept operands
- ina  input  WIDTH  operand A
- inb  input  WIDTH  operand B
- cin  input  1  carry-in to nibble 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of the top nibble
- busy  output  1  high in RUN or DONE
- sub  input  1  present only with SUB_EN_EN; 1 selects A-B

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0; nibble index=0, carry register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch ina, inb and cin into the carry register, set index=0, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle the slice computes A[4i+3:4i] + B[4i+3:4i] + carry_reg.
  - At the edge, write the 4-bit result into sum[4i+3:4i], load the slice carry-out into carry_reg, increment i.
  - When i==NIB-1, at that edge: cout takes the slice carry-out, state goes to DONE, out_valid=1.
- Latency: out_valid rises exactly NIB cycles after the accept edge (4 for WIDTH=16).
- DONE:
  - out_valid=1; sum and cout held stable until out_valid&out_ready.
  - Then go to IDLE and drop out_valid.
  - in_ready stays 0 in DONE, so no overlap. Throughput is one operation per NIB+2 cycles with out_ready tied high.
- Inputs ina/inb/cin are ignored outside the IDLE accept edge. Changing them during RUN has no effect.
- in_valid arriving during RUN or DONE stays pending and is not accepted until IDLE (producer must hold it).
- Arithmetic: result is (ina+inb+cin) mod 2^WIDTH; cout is bit WIDTH of the full sum. Fully unsigned; no overflow flag.
- WIDTH=4: RUN lasts one cycle.
- sum bits not yet written during RUN retain the previous result; only the DONE value is architecturally valid.
- rst asserted mid-RUN or in DONE: immediate return to reset values; the in-flight operation is discarded with no out_valid.

Optional Feature:
- Macro SUB_EN_EN.
- Defined:
  - Port sub exists and is latched at accept.
  - When sub=1, the controller feeds ~inb to the slice each step and forces the initial carry to 1 (cin ignored): result = ina-inb mod 2^WIDTH.
  - cout=1 means no borrow (ina>=inb).
  - sub=0 behaves exactly as the add path.
- Undefined: no sub port, add only; logic identical to the add path.

Test Plan:
- WIDTH=16, ina=0x1234, inb=0x0FFF, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0x2233, cout=0; in_ready back to 1 one cycle after the result handshake.
- ina=0xFFFF, inb=0x0000, cin=1 -> carry ripples through all 4 nibbles; sum=0x0000, cout=1.
- ina=0x8000, inb=0x8000, cin=0; out_ready held 0 for 3 cycles -> sum=0x0000, cout=1 held stable, out_valid=1, in_ready=0 throughout; released after out_ready=1.
- Accept 0x00FF+0x0001; change ina/inb to 0xAAAA/0x5555 during RUN; pulse rst after 2 RUN cycles -> all outputs at reset values immediately, no out_valid; next op 0x0003+0x0004+1 gives sum=0x0008, cout=0.
- SUB_EN_EN defined: ina=0x0005, inb=0x0007, sub=1 -> sum=0xFFFE, cout=0. Then ina=0x0007, inb=0x0005, sub=1 -> sum=0x0002, cout=1.
- WIDTH=4 instance: ina=0x9, inb=0x8, cin=1 -> out_valid 1 cycle after accept; sum=0x2, cout=1.
